// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared definitions for the direct-mapped data cache.
//   - FSM state encodings (IDLE, WRITEBACK, FETCH, FILL)
//   - field widths of the 8-bit byte address (tag[7:5], index[4:2], offset[1:0])
//   - block width and line count
package data_cache_pkg;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 32;
  localparam int LINES    = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    FILL      = 2'd3
  } dc_state_e;

endpackage

// File: rtl/data_cache_line_array.sv
// dcache_line_array: storage for the 8 x 4-byte lines of the data cache.
// Holds valid/dirty bits (asynchronously cleared), tags and block data,
// performs the tag compare and the byte select/merge.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset (valid/dirty only)
//   idx_i, tag_i, off_i     lookup fields of the current CPU address
//   wr_en_i, wr_byte_i      write-hit byte store into the looked-up line
//   fill_en_i, fill_*_i     whole-line refill with new tag (sets valid, clears dirty)
//   hit_o                   looked-up line is valid and tag matches
//   valid_o, dirty_o,
//   tag_o, data_o           state of the looked-up line (victim for write-back)
//   rd_byte_o               byte at off_i within the looked-up line
module dcache_line_array
  import data_cache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [INDEX_W-1:0]  idx_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic [OFFSET_W-1:0] off_i,
  input  logic                wr_en_i,
  input  logic [7:0]          wr_byte_i,
  input  logic                fill_en_i,
  input  logic [INDEX_W-1:0]  fill_idx_i,
  input  logic [TAG_W-1:0]    fill_tag_i,
  input  logic [BLOCK_W-1:0]  fill_data_i,
  output logic                hit_o,
  output logic                valid_o,
  output logic                dirty_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic [BLOCK_W-1:0]  data_o,
  output logic [7:0]          rd_byte_o
);

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
      dirty_q[fill_idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data carry no reset; they are meaningless until valid is set.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_data_i;
    end else if (wr_en_i) begin
      data_q[idx_i][{off_i, 3'b000} +: 8] <= wr_byte_i;
    end
  end

  assign valid_o   = valid_q[idx_i];
  assign dirty_o   = dirty_q[idx_i];
  assign tag_o     = tag_q[idx_i];
  assign data_o    = data_q[idx_i];
  assign hit_o     = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
  assign rd_byte_o = data_o[{off_i, 3'b000} +: 8];

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache
// (8 lines x 4 bytes) between the CPU byte port and 256-byte data memory.
// Optional feature macro: DCACHE_STATS_EN adds saturating hit/miss counters.
// Ports:
//   CLK, RESET                  clock, asynchronous active-high reset
//   read, write, address,
//   writedata, readdata         CPU byte load/store interface
//   busywait                    CPU stall
//   mem_read, mem_write,
//   mem_address, mem_writedata,
//   mem_readdata, mem_busywait  4-byte block memory handshake
//   hit_count, miss_count       (DCACHE_STATS_EN only) 16-bit saturating counters
module data_cache
  import data_cache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  dc_state_e          state_q, state_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [5:0]         mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0] miss_idx_q, miss_idx_d;
  logic [BLOCK_W-1:0] fill_data_q, fill_data_d;
  logic [7:0]         rdata_q;

  logic               busy, wr_hit, rd_hit, fill_en;
  logic               hit, line_valid, line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [BLOCK_W-1:0] line_data;
  logic [7:0]         rd_byte;

  logic [TAG_W-1:0]    a_tag;
  logic [INDEX_W-1:0]  a_idx;
  logic [OFFSET_W-1:0] a_off;
  assign a_tag = address[7:5];
  assign a_idx = address[4:2];
  assign a_off = address[1:0];

  dcache_line_array u_lines (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .idx_i       (a_idx),
    .tag_i       (a_tag),
    .off_i       (a_off),
    .wr_en_i     (wr_hit),
    .wr_byte_i   (writedata),
    .fill_en_i   (fill_en),
    .fill_idx_i  (miss_idx_q),
    .fill_tag_i  (miss_tag_q),
    .fill_data_i (fill_data_q),
    .hit_o       (hit),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .data_o      (line_data),
    .rd_byte_o   (rd_byte)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      miss_tag_q  <= '0;
      miss_idx_q  <= '0;
      fill_data_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      miss_tag_q  <= miss_tag_d;
      miss_idx_q  <= miss_idx_d;
      fill_data_q <= fill_data_d;
      rdata_q     <= readdata;
    end
  end

  // Memory requests are computed one cycle ahead and registered, so they
  // never glitch and stay stable for the whole transfer. The miss line is
  // latched so the fill completes correctly even if the CPU drops its request.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    miss_tag_d  = miss_tag_q;
    miss_idx_d  = miss_idx_q;
    fill_data_d = fill_data_q;
    busy        = 1'b0;
    wr_hit      = 1'b0;
    rd_hit      = 1'b0;
    fill_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          if (hit) begin
            wr_hit = write;
            rd_hit = read && !write;
          end else begin
            busy       = 1'b1;
            miss_tag_d = a_tag;
            miss_idx_d = a_idx;
            if (line_valid && line_dirty) begin
              state_d     = WRITEBACK;
              mem_write_d = 1'b1;
              mem_addr_d  = {line_tag, a_idx};
              mem_wdata_d = line_data;
            end else begin
              state_d    = FETCH;
              mem_read_d = 1'b1;
              mem_addr_d = {a_tag, a_idx};
            end
          end
        end
      end
      WRITEBACK: begin
        busy = 1'b1;
        if (!mem_busywait) begin
          state_d     = FETCH;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = {miss_tag_q, miss_idx_q};
        end
      end
      FETCH: begin
        busy = 1'b1;
        if (!mem_busywait) begin
          state_d     = FILL;
          mem_read_d  = 1'b0;
          fill_data_d = mem_readdata;
        end
      end
      FILL: begin
        busy    = 1'b1;
        fill_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // While RESET is held the FSM is forced to IDLE, so no stall is reported.
  assign busywait      = busy && !RESET;
  assign readdata      = rd_hit ? rd_byte : rdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_addr_q;
  assign mem_writedata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        fill_prev_q;
  logic        miss_start, hit_done;

  assign miss_start = (state_q == IDLE) && (state_d != IDLE);
  // The hit that completes a miss right after FILL is not a separate hit.
  assign hit_done   = (state_q == IDLE) && (read || write) && hit && !fill_prev_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      fill_prev_q <= 1'b0;
    end else begin
      fill_prev_q <= (state_q == FILL);
      if (miss_start && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
      if (hit_done && (hit_cnt_q != 16'hFFFF))    hit_cnt_q  <= hit_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Testbench for data_cache: directed vector table, hand-written corner
// sequences (reset values, transfer log, reset during FETCH) and a random
// phase checked against an abstract cache/memory reference model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        RESET;
  logic        read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  data_cache dut (
    .CLK           (clk),
    .RESET         (RESET),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  // ---------------- memory responder ----------------
  logic [7:0]  mem [256];
  int          lat = 0;
  int          mcnt = 0;
  logic        init_mem;
  int          excl_viol = 0;
  int          log_n = 0;
  logic        log_wr   [16];
  logic [5:0]  log_addr [16];
  logic [31:0] log_data [16];

  assign mem_busywait = (mem_read || mem_write) && (mcnt < lat);
  assign mem_readdata = {mem[{mem_address, 2'd3}], mem[{mem_address, 2'd2}],
                         mem[{mem_address, 2'd1}], mem[{mem_address, 2'd0}]};

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC3;
      mcnt <= 0;
    end else begin
      if (mem_read && mem_write) excl_viol <= excl_viol + 1;
      if (mem_read || mem_write) begin
        if (mcnt < lat) mcnt <= mcnt + 1;
        else begin
          mcnt <= 0;
          if (mem_write)
            for (int k = 0; k < 4; k++) mem[{mem_address, 2'(k)}] <= mem_writedata[8*k +: 8];
          if (log_n < 16) begin
            log_wr[log_n]   <= mem_write;
            log_addr[log_n] <= mem_address;
            log_data[log_n] <= mem_writedata;
          end
          log_n <= log_n + 1;
        end
      end else mcnt <= 0;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one CPU access, counts the cycles busywait is high, samples
  // readdata in the completing cycle, then drops the request after the edge.
  task automatic access(input bit r, input bit w, input logic [7:0] a, input logic [7:0] wd,
                        output int stall, output logic [7:0] rd);
    @(negedge clk);
    read = r; write = w; address = a; writedata = wd;
    #1;
    stall = 0;
    while (busywait !== 1'b0 && stall < 100) begin
      @(negedge clk);
      #1;
      stall++;
    end
    rd = readdata;
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Architectural memory contents plus which block each line holds.
  logic [7:0] arch [256];
  bit         mv [8];
  bit         md [8];
  int         mt [8];

  task automatic model_reset_sync();
    for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; mt[i] = 0; end
    for (int i = 0; i < 256; i++) arch[i] = mem[i];
  endtask

  task automatic model(input bit r, input bit w, input logic [7:0] a, input logic [7:0] wd,
                       output int st, output logic [7:0] rd);
    int idx, t, n;
    idx = a / 4 % 8;
    t   = a / 32;
    n   = lat + 1;
    st  = 0;
    if (!(mv[idx] && mt[idx] == t)) begin
      st = 2 + n + ((mv[idx] && md[idx]) ? n : 0);
      mv[idx] = 1; mt[idx] = t; md[idx] = 0;
    end
    if (w) begin arch[a] = wd; md[idx] = 1; end
    rd = arch[a];
    if (r) ;
  endtask

  typedef struct {
    bit         r;
    bit         w;
    logic [7:0] a;
    logic [7:0] wd;
    int         lat;
    int         exp_stall;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int         st, mst, base;
    logic [7:0] rd, mrd;
    int         mism;

    vecs[0]  = '{1, 0, 8'h00, 8'h00, 0, 0, 8'h00};
    vecs[0]  = '{0, 1, 8'h05, 8'hAA, 0, 3,  8'h00};
    vecs[1]  = '{1, 0, 8'h05, 8'h00, 0, 0,  8'hAA};
    vecs[2]  = '{1, 0, 8'h25, 8'h00, 0, 4,  8'hE6};
    vecs[3]  = '{1, 0, 8'h05, 8'h00, 5, 8,  8'hAA};
    vecs[4]  = '{0, 1, 8'h05, 8'h55, 5, 0,  8'h00};
    vecs[5]  = '{1, 0, 8'h25, 8'h00, 5, 14, 8'hE6};
    vecs[6]  = '{0, 1, 8'h1F, 8'h77, 0, 3,  8'h00};
    vecs[7]  = '{1, 0, 8'h1F, 8'h00, 0, 0,  8'h77};
    vecs[8]  = '{1, 0, 8'h1E, 8'h00, 0, 0,  8'hDD};
    vecs[9]  = '{1, 1, 8'h1F, 8'h99, 0, 0,  8'h00};
    vecs[10] = '{1, 0, 8'h1F, 8'h00, 0, 0,  8'h99};
    vecs[11] = '{1, 0, 8'h05, 8'h00, 2, 5,  8'h55};

    read = 0; write = 0; address = 0; writedata = 0;
    RESET = 1'b1; init_mem = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busywait", 32'(busywait), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_address", 32'(mem_address), 0);
    chk("rst_mem_writedata", mem_writedata, 0);
    chk("rst_readdata", 32'(readdata), 0);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_count", 32'(hit_count), 0);
    chk("rst_miss_count", 32'(miss_count), 0);
`endif
    @(negedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    RESET = 1'b0;
    model_reset_sync();
    base = log_n;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      lat = vecs[i].lat;
      access(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd, st, rd);
      model(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].wd, mst, mrd);
      chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
      if (vecs[i].r && !vecs[i].w)
        chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
`ifdef DCACHE_STATS_EN
      if (i == 2) begin
        chk("stats_miss_count", 32'(miss_count), 2);
        chk("stats_hit_count", 32'(hit_count), 1);
      end
`endif
    end

    // Transfer log of the first three vectors: fetch, write-back, fetch.
    chk("log0_is_write", 32'(log_wr[base]), 0);
    chk("log0_addr", 32'(log_addr[base]), 32'h01);
    chk("log1_is_write", 32'(log_wr[base+1]), 1);
    chk("log1_addr", 32'(log_addr[base+1]), 32'h01);
    chk("log1_wdata_byte1", 32'(log_data[base+1][15:8]), 32'hAA);
    chk("log2_is_write", 32'(log_wr[base+2]), 0);
    chk("log2_addr", 32'(log_addr[base+2]), 32'h09);

    // RESET pulsed while the FSM is fetching.
    lat = 5;
    @(negedge clk);
    read = 1'b1; write = 1'b0; address = 8'h45;
    st = 0;
    while (mem_read !== 1'b1 && st < 50) begin @(negedge clk); st++; end
    chk("rstmid_reached_fetch", 32'(mem_read), 1);
    @(negedge clk);
    RESET = 1'b1;
    #1;
    chk("rstmid_mem_read_drop", 32'(mem_read), 0);
    chk("rstmid_mem_write_low", 32'(mem_write), 0);
    chk("rstmid_busywait", 32'(busywait), 0);
    @(negedge clk);
    RESET = 1'b0; read = 1'b0;
    @(negedge clk);
    model_reset_sync();
    access(1, 0, 8'h45, 8'h00, st, rd);
    model(1, 0, 8'h45, 8'h00, mst, mrd);
    chk("rstmid_remiss_stall", 32'(st), 32'(mst));
    chk("rstmid_remiss_rdata", 32'(rd), 32'(mrd));

    // Random phase against the reference model.
    for (int i = 0; i < 400; i++) begin
      bit         r, w;
      logic [7:0] a, wd;
      lat = $urandom_range(0, 3);
      a   = {3'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)};
      wd  = 8'($urandom);
      w   = ($urandom_range(0, 2) == 0);
      r   = !w || ($urandom_range(0, 7) == 0);
      access(r, w, a, wd, st, rd);
      model(r, w, a, wd, mst, mrd);
      chk($sformatf("rnd%0d_stall a=%0h", i, a), 32'(st), 32'(mst));
      if (r && !w)
        chk($sformatf("rnd%0d_rdata a=%0h", i, a), 32'(rd), 32'(mrd));
    end

    // Memory must agree with the model wherever no dirty line shadows it.
    @(negedge clk);
    mism = 0;
    for (int a = 0; a < 256; a++) begin
      int idx;
      idx = a / 4 % 8;
      if (!(mv[idx] && mt[idx] == a / 32 && md[idx]) && mem[a] !== arch[a]) mism++;
    end
    chk("memsync_mismatches", 32'(mism), 0);
    chk("mem_read_write_exclusive", 32'(excl_viol), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
